// File: rtl/dffram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dffram_arbiter_if
//
// Bundles every signal that connects the DFFRAM arbiter to its three
// neighbours: the management CPU memory port, the housekeeping read-only
// port and the single-port DFFRAM macro.
//
// Parameters
//   AW : RAM word-address width
//   DW : data width; byte enables are DW/8 bits wide
//
// Signal groups
//   CPU port  : cpu_req, cpu_wen, cpu_addr, cpu_wdata  -> arbiter
//               cpu_gnt, cpu_rvalid, cpu_rdata         <- arbiter
//   HK port   : hk_req, hk_addr                        -> arbiter
//               hk_gnt, hk_rvalid, hk_rdata            <- arbiter
//   RAM macro : ram_en, ram_we, ram_addr, ram_wdata    <- arbiter
//               ram_rdata                              -> arbiter
//
// Modports
//   slave  : the arbiter itself
//   master : the surrounding system (requesters plus the RAM macro)
// -----------------------------------------------------------------------------
interface dffram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  // CPU memory port
  logic          cpu_req;
  logic [BW-1:0] cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  // Housekeeping read-only port
  logic          hk_req;
  logic [AW-1:0] hk_addr;
  logic          hk_gnt;
  logic          hk_rvalid;
  logic [DW-1:0] hk_rdata;

  // DFFRAM macro
  logic          ram_en;
  logic [BW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  hk_req, hk_addr,
    input  ram_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output hk_gnt, hk_rvalid, hk_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output hk_req, hk_addr,
    output ram_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  hk_gnt, hk_rvalid, hk_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dffram_arbiter.sv
// -----------------------------------------------------------------------------
// dffram_arbiter
//
// Shares one single-port DFFRAM between the management CPU memory port
// (read/write) and the housekeeping port (read-only). Grants are purely
// combinational so a granted request reaches the macro in the same cycle;
// read data comes back with the macro's one-cycle latency.
//
// The CPU has priority. A saturating wait counter counts consecutive
// conflict cycles the housekeeping port has lost; once it reaches
// HK_MAX_WAIT the next conflict goes to housekeeping, which bounds its
// wait under sustained CPU traffic.
//
// Parameters
//   AW          : RAM word-address width
//   DW          : data width (DW/8 byte enables)
//   HK_MAX_WAIT : conflicts housekeeping may lose in a row before winning;
//                 0 makes housekeeping win every conflict
//
// Ports
//   core_clk : clock, all state on the rising edge
//   core_rst : synchronous active-high reset
//   bus      : dffram_arbiter_if.slave carrying the CPU port, the
//              housekeeping port and the DFFRAM macro pins
// -----------------------------------------------------------------------------
module dffram_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int HK_MAX_WAIT = 4
) (
  input  logic             core_clk,
  input  logic             core_rst,
  dffram_arbiter_if.slave  bus
);

  localparam int BW  = DW / 8;
  // clog2(HK_MAX_WAIT+1), but never narrower than one bit
  localparam int WCW = (HK_MAX_WAIT > 0) ? $clog2(HK_MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(HK_MAX_WAIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WCW-1:0] wait_cnt_q,   wait_cnt_d;
  logic           issued_cpu_q, issued_cpu_d;
  logic           issued_hk_q,  issued_hk_d;
  logic [DW-1:0]  hk_rdata_q,   hk_rdata_d;

  // ---------------------------------------------------------------------------
  // Combinational arbitration and RAM mux
  // ---------------------------------------------------------------------------
  logic           hk_wins;
  logic           cpu_gnt;
  logic           hk_gnt;
  logic           ram_en;
  logic [BW-1:0]  ram_we;
  logic [AW-1:0]  ram_addr;
  logic [DW-1:0]  ram_wdata;

  always_comb begin
    // Housekeeping wins when it is alone, or when it has already lost
    // WAIT_MAX conflicts in a row.
    hk_wins = bus.hk_req && (!bus.cpu_req || (wait_cnt_q == WAIT_MAX));

    // Reset masks both grants so nothing reaches the macro.
    cpu_gnt = !core_rst && bus.cpu_req && !hk_wins;
    hk_gnt  = !core_rst && hk_wins;

    ram_en    = cpu_gnt || hk_gnt;
    // Housekeeping is read-only, so only a CPU grant can enable writes.
    ram_we    = cpu_gnt ? bus.cpu_wen : '0;
    // With no grant the address/data simply follow the CPU port.
    ram_addr  = hk_gnt ? bus.hk_addr : bus.cpu_addr;
    ram_wdata = bus.cpu_wdata;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic cpu_rvalid;
  logic hk_rvalid;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    // The count only means something while housekeeping keeps asking and
    // keeps losing; any grant to it or any idle cycle starts it over.
    if (!bus.hk_req || hk_gnt) begin
      wait_cnt_d = '0;
    end else if (cpu_gnt && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    issued_cpu_d = cpu_gnt;
    issued_hk_d  = hk_gnt;

    // Keeps the last housekeeping read word visible between completions.
    hk_rdata_d = hk_rvalid ? bus.ram_rdata : hk_rdata_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      wait_cnt_q   <= '0;
      issued_cpu_q <= 1'b0;
      issued_hk_q  <= 1'b0;
      hk_rdata_q   <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      issued_cpu_q <= issued_cpu_d;
      issued_hk_q  <= issued_hk_d;
      hk_rdata_q   <= hk_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion side
  // ---------------------------------------------------------------------------
  logic [DW-1:0] cpu_rdata;
  logic [DW-1:0] hk_rdata;

  always_comb begin
    // A grant followed directly by reset must not report a completion, so
    // the issued flags are masked while reset is high, not only cleared
    // on the following edge.
    cpu_rvalid = issued_cpu_q && !core_rst;
    hk_rvalid  = issued_hk_q  && !core_rst;

    cpu_rdata  = cpu_rvalid ? bus.ram_rdata : '0;

    if (core_rst) begin
      hk_rdata = '0;
    end else if (hk_rvalid) begin
      hk_rdata = bus.ram_rdata;
    end else begin
      hk_rdata = hk_rdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.hk_gnt     = hk_gnt;
  assign bus.hk_rvalid  = hk_rvalid;
  assign bus.hk_rdata   = hk_rdata;
  assign bus.ram_en     = ram_en;
  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;

`ifndef SYNTHESIS
  // Structural invariants of the arbiter.
  a_gnt_exclusive : assert property (@(posedge core_clk) !(cpu_gnt && hk_gnt));
  a_hk_no_write   : assert property (@(posedge core_clk) hk_gnt |-> (ram_we == '0));
  a_wait_bounded  : assert property (@(posedge core_clk) wait_cnt_q <= WAIT_MAX);
`endif

endmodule

// File: tb/tb_dffram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dffram_arbiter
//
// Scoreboard bench for dffram_arbiter. A driver feeds the CPU and
// housekeeping ports from stimulus queues and honours the hold-until-grant
// rule. A predictor decides each cycle who must be granted from the
// arbitration rules, keeps a word-array image of the RAM and pushes expected
// completions; a separate monitor pops them when the DUT reports rvalid.
// A second instance with HK_MAX_WAIT=0 is exercised directly.
// -----------------------------------------------------------------------------
module tb_dffram_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dffram_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
  dffram_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

  dffram_arbiter #(.AW(AW), .DW(DW), .HK_MAX_WAIT(MAXW)) dut (
    .core_clk (clk),
    .core_rst (rst),
    .bus      (bus)
  );

  dffram_arbiter #(.AW(AW), .DW(DW), .HK_MAX_WAIT(0)) dut0 (
    .core_clk (clk),
    .core_rst (rst),
    .bus      (bus0)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural DFFRAM for the main instance
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram [0:255];
  bit            ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      bus.ram_rdata <= '0;
      ram_init      <= 1'b1;
    end else if (bus.ram_en) begin
      bus.ram_rdata <= ram[bus.ram_addr];
      for (int b = 0; b < BW; b++)
        if (bus.ram_we[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  assign bus0.ram_rdata = '0;

  // ---------------------------------------------------------------------------
  // Stimulus queues and driver
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            req;
    logic [BW-1:0] wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cpu_item_t;

  typedef struct {
    bit            req;
    logic [AW-1:0] addr;
  } hk_item_t;

  typedef struct {
    int            cyc;
    bit            chk;
    logic [DW-1:0] data;
  } exp_t;

  cpu_item_t cpu_stim[$];
  hk_item_t  hk_stim[$];
  exp_t      cpu_exp[$];
  exp_t      hk_exp[$];

  bit cpu_granted = 1'b0;
  bit hk_granted  = 1'b0;

  cpu_item_t ci;
  hk_item_t  hi;

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_wen   = '0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.hk_req    = 1'b0;
    bus.hk_addr   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.cpu_req && cpu_granted) bus.cpu_req = 1'b0;
      if (!bus.cpu_req && cpu_stim.size() > 0) begin
        ci = cpu_stim.pop_front();
        bus.cpu_req = ci.req;
        if (ci.req) begin
          bus.cpu_wen   = ci.wen;
          bus.cpu_addr  = ci.addr;
          bus.cpu_wdata = ci.data;
        end
      end
      if (bus.hk_req && hk_granted) bus.hk_req = 1'b0;
      if (!bus.hk_req && hk_stim.size() > 0) begin
        hi = hk_stim.pop_front();
        bus.hk_req = hi.req;
        if (hi.req) bus.hk_addr = hi.addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Predictor: expected grants, RAM image, expected completions
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mdl [0:255];
  int            lost          = 0;
  int            hk_wait_start = -1;
  int            last_hk_wait  = -1;
  bit            p_c, p_h;
  logic [BW-1:0] p_we;
  logic [AW-1:0] p_addr;

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    forever begin
      @(negedge clk);
      p_c = 1'b0;
      p_h = 1'b0;
      if (rst) begin
        lost          = 0;
        hk_wait_start = -1;
      end else if (bus.cpu_req && bus.hk_req) begin
        if (lost < MAXW) begin
          p_c = 1'b1;
          lost++;
        end else begin
          p_h  = 1'b1;
          lost = 0;
        end
      end else begin
        p_c  = bus.cpu_req;
        p_h  = bus.hk_req;
        lost = 0;
      end

      p_we   = p_c ? bus.cpu_wen : '0;
      p_addr = p_h ? bus.hk_addr : bus.cpu_addr;
      check("grant_en_we", {bus.cpu_gnt, bus.hk_gnt, bus.ram_en, bus.ram_we},
                           {p_c, p_h, (p_c | p_h), p_we});
      check("ram_addr_wdata", {bus.ram_addr, bus.ram_wdata}, {p_addr, bus.cpu_wdata});

      if (!rst && bus.hk_req && hk_wait_start < 0) hk_wait_start = cyc;
      if (p_h) begin
        last_hk_wait  = cyc - hk_wait_start;
        hk_wait_start = -1;
        hk_exp.push_back('{cyc: cyc, chk: 1'b1, data: mdl[bus.hk_addr]});
      end
      if (p_c) begin
        cpu_exp.push_back('{cyc: cyc, chk: (bus.cpu_wen == '0), data: mdl[bus.cpu_addr]});
        for (int b = 0; b < BW; b++)
          if (bus.cpu_wen[b]) mdl[bus.cpu_addr][8*b +: 8] = bus.cpu_wdata[8*b +: 8];
      end
      cpu_granted = p_c;
      hk_granted  = p_h;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: completions against the expected queues
  // ---------------------------------------------------------------------------
  logic [DW-1:0] hk_last     = '0;
  logic [DW-1:0] last_cpu_rd = '0;
  exp_t          e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_rvalid", {bus.cpu_rvalid, bus.hk_rvalid}, 2'b00);
        check("rst_rdata", {bus.cpu_rdata, bus.hk_rdata}, 64'h0);
        cpu_exp.delete();
        hk_exp.delete();
        hk_last = '0;
      end else begin
        if (bus.cpu_rvalid) begin
          if (cpu_exp.size() == 0) begin
            check("cpu_rvalid_unexpected", 1, 0);
          end else begin
            e = cpu_exp.pop_front();
            check("cpu_latency", cyc, e.cyc + 1);
            if (e.chk) begin
              check("cpu_rdata", bus.cpu_rdata, e.data);
              last_cpu_rd = bus.cpu_rdata;
            end
          end
        end else begin
          check("cpu_rdata_idle", bus.cpu_rdata, 0);
          if (cpu_exp.size() > 0 && cpu_exp[0].cyc < cyc) begin
            check("cpu_rvalid_missing", 0, 1);
            void'(cpu_exp.pop_front());
          end
        end

        if (bus.hk_rvalid) begin
          if (hk_exp.size() == 0) begin
            check("hk_rvalid_unexpected", 1, 0);
          end else begin
            e = hk_exp.pop_front();
            check("hk_latency", cyc, e.cyc + 1);
            check("hk_rdata", bus.hk_rdata, e.data);
            hk_last = e.data;
          end
        end else begin
          check("hk_rdata_hold", bus.hk_rdata, hk_last);
          if (hk_exp.size() > 0 && hk_exp[0].cyc < cyc) begin
            check("hk_rvalid_missing", 0, 1);
            void'(hk_exp.pop_front());
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequences
  // ---------------------------------------------------------------------------
  task automatic push_cpu(input logic [BW-1:0] wen, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    cpu_stim.push_back('{req: 1'b1, wen: wen, addr: addr, data: data});
  endtask

  task automatic push_hk(input logic [AW-1:0] addr);
    hk_stim.push_back('{req: 1'b1, addr: addr});
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cpu_stim.size() == 0 && hk_stim.size() == 0 && !bus.cpu_req && !bus.hk_req &&
          cpu_exp.size() == 0 && hk_exp.size() == 0) break;
    end
    if (k == 2000) check("drain_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  int k;

  initial begin
    rst            = 1'b1;
    bus0.cpu_req   = 1'b0;
    bus0.cpu_wen   = '0;
    bus0.cpu_addr  = '0;
    bus0.cpu_wdata = '0;
    bus0.hk_req    = 1'b0;
    bus0.hk_addr   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full write, read back, byte write, read back.
    @(negedge clk);
    push_cpu(4'hF, 8'h10, 32'hDEADBEEF);
    push_cpu(4'h0, 8'h10, 32'h0);
    drain();
    check("dir_full_write", last_cpu_rd, 32'hDEADBEEF);
    push_cpu(4'h2, 8'h10, 32'h0000AA00);
    push_cpu(4'h0, 8'h10, 32'h0);
    drain();
    check("dir_byte_write", last_cpu_rd, 32'hDEADAAEF);

    // Housekeeping read alone, then held through idle cycles.
    push_hk(8'h10);
    drain();
    repeat (10) @(negedge clk);
    check("dir_hk_hold", bus.hk_rdata, 32'hDEADAAEF);

    // Sustained CPU traffic with housekeeping raised in the same cycle.
    for (int i = 0; i < 8; i++) push_cpu(4'h0, 8'(i), 32'h0);
    push_hk(8'h10);
    drain();
    check("dir_hk_wait", last_hk_wait, MAXW);

    // Reset in the cycle after a CPU read grant.
    push_cpu(4'h0, 8'h10, 32'h0);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cpu_granted) break;
    end
    if (k == 20) check("rst_seq_timeout", 1, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_after_grant", {bus.cpu_rvalid, bus.cpu_gnt, bus.hk_gnt, bus.ram_en}, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fresh housekeeping read, then a conflict run that must start counting at 0.
    @(negedge clk);
    push_hk(8'h10);
    drain();
    check("post_rst_hk", bus.hk_rdata, 32'hDEADAAEF);
    for (int i = 0; i < 6; i++) push_cpu(4'h1, 8'(8'h20 + i), 32'h11223344 + i);
    push_hk(8'h21);
    drain();
    check("post_rst_hk_wait", last_hk_wait, MAXW);

    // Randomised mixed traffic.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 99) < 60)
        push_cpu(($urandom_range(0, 3) < 2) ? 4'h0 : 4'($urandom),
                 8'($urandom_range(0, 15)), $urandom);
      else
        cpu_stim.push_back('{req: 1'b0, wen: '0, addr: '0, data: '0});
      if ($urandom_range(0, 99) < 50)
        push_hk(8'($urandom_range(0, 15)));
      else
        hk_stim.push_back('{req: 1'b0, addr: '0});
    end
    drain();

    // HK_MAX_WAIT = 0: housekeeping takes every conflict.
    @(posedge clk);
    #1;
    bus0.cpu_req  = 1'b1;
    bus0.cpu_addr = 8'h05;
    bus0.hk_req   = 1'b1;
    bus0.hk_addr  = 8'h07;
    @(negedge clk);
    check("hk0_conflict", {bus0.cpu_gnt, bus0.hk_gnt, bus0.ram_we, bus0.ram_addr},
                          {2'b01, 4'h0, 8'h07});
    @(posedge clk);
    #1 bus0.hk_req = 1'b0;
    @(negedge clk);
    check("hk0_cpu_after", {bus0.cpu_gnt, bus0.hk_gnt, bus0.hk_rvalid}, 3'b101);
    @(posedge clk);
    #1 bus0.cpu_req = 1'b0;
    @(negedge clk);
    check("hk0_cpu_rvalid", {bus0.cpu_rvalid, bus0.cpu_gnt, bus0.ram_en}, 3'b100);

    check("scoreboard_empty", cpu_exp.size() + hk_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
